// File: rtl/led_breathe.sv
// LED breathing stage: ramps a PWM duty up and down while EN is high and
// fades it out quickly when EN drops.
module led_breathe #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 1024,
  parameter int unsigned MAX_DUTY = 2**PWM_BITS-1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  output logic                LED,
  output logic [PWM_BITS-1:0] DUTY,
  output logic [1:0]          PHASE,
  output logic                PEAK
);

  localparam int unsigned PreW = $clog2(STEP_DIV);
  localparam logic [PreW-1:0]     PreLast = PreW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] DutyPre = PWM_BITS'(MAX_DUTY - 1);
  localparam logic [PWM_BITS-1:0] DutyOne = PWM_BITS'(1);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StRise = 2'b01;
  localparam logic [1:0] StFall = 2'b10;
  localparam logic [1:0] StFade = 2'b11;

  logic                en_meta_q, en_s_q;
  logic [1:0]          state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                peak_q, peak_d;
  logic [PreW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic                led_q, led_d;
  logic                step;

  always_comb begin
    step = (state_q != StIdle) && (pre_cnt_q == PreLast);
    if (state_q == StIdle) begin
      pre_cnt_d = '0;
    end else if (step) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    peak_d  = 1'b0;
    case (state_q)
      StIdle: begin
        duty_d = '0;
        if (en_s_q) state_d = StRise;
      end
      StRise: begin
        if (!en_s_q) begin
          state_d = StFade;
        end else if (step) begin
          if (duty_q >= DutyPre) begin
            duty_d  = DutyMax;
            state_d = StFall;
            peak_d  = 1'b1;
          end else begin
            duty_d = duty_q + 1'b1;
          end
        end
      end
      StFall: begin
        // Reaching zero wins over the fade request: a finished breath simply idles.
        if (step && (duty_q <= DutyOne)) begin
          duty_d  = '0;
          state_d = en_s_q ? StRise : StIdle;
        end else if (!en_s_q) begin
          state_d = StFade;
        end else if (step) begin
          duty_d = duty_q - 1'b1;
        end
      end
      default: begin
        if (duty_q == '0) begin
          state_d = StIdle;
        end else if (step) begin
          if (int'(duty_q) <= 4) begin
            duty_d  = '0;
            state_d = StIdle;
          end else begin
            duty_d = duty_q - PWM_BITS'(4);
          end
        end
      end
    endcase
  end

  // Duty is sampled only at the carrier wrap so a period never sees two duty values.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    duty_act_d = (&pwm_cnt_q) ? duty_q : duty_act_q;
    led_d      = (pwm_cnt_q < duty_act_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_meta_q  <= 1'b0;
      en_s_q     <= 1'b0;
      state_q    <= StIdle;
      duty_q     <= '0;
      peak_q     <= 1'b0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      duty_act_q <= '0;
      led_q      <= 1'b0;
    end else begin
      en_meta_q  <= EN;
      en_s_q     <= en_meta_q;
      state_q    <= state_d;
      duty_q     <= duty_d;
      peak_q     <= peak_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_act_q <= duty_act_d;
      led_q      <= led_d;
    end
  end

  assign LED   = led_q;
  assign DUTY  = duty_q;
  assign PHASE = state_q;
  assign PEAK  = peak_q;

endmodule
